// File: rtl/starsoc_video_pkg.sv
// Shared 640x480 timing constants and sync-recovery state type for the StarSoC display path.
package starsoc_video_pkg;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;
  localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} sync_state_t;

  // 11-bit increment that sticks at all-ones
  function automatic logic [10:0] sat_inc11(input logic [10:0] v);
    return (v == 11'h7FF) ? v : v + 11'd1;
  endfunction

endpackage

// File: rtl/hdmi_sync_decoder_if.sv
// Sync input / recovered-grid output bundle between a video source and hdmi_sync_decoder.
interface hdmi_sync_decoder_if;
  logic        p_tick;
  logic        hsync;
  logic        vsync;
  logic        video_on;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        pix_valid;
  logic        frame_start;
  logic        locked;
  logic        sync_err;
  logic [10:0] h_total_meas;
  logic [10:0] v_total_meas;

  modport master (
    output p_tick, hsync, vsync, video_on,
    input  x, y, pix_valid, frame_start, locked, sync_err, h_total_meas, v_total_meas
  );

  modport slave (
    input  p_tick, hsync, vsync, video_on,
    output x, y, pix_valid, frame_start, locked, sync_err, h_total_meas, v_total_meas
  );
endinterface

// File: rtl/hdmi_sync_decoder_edge.sv
// sync_edge_detect: polarity-normalises one sync line and flags pixel-tick-qualified edges.
module sync_edge_detect #(
  parameter bit POL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic p_tick,
  input  logic sig_in,
  output logic lvl,
  output logic rise,
  output logic fall
);

  logic prev_q, prev_d;

  always_comb begin
    lvl    = (sig_in == POL);
    prev_d = p_tick ? lvl : prev_q;
    rise   = p_tick & lvl & ~prev_q;
    fall   = p_tick & ~lvl & prev_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) prev_q <= 1'b0;
    else       prev_q <= prev_d;
  end

endmodule

// File: rtl/hdmi_sync_decoder.sv
// Sink-side timing recovery: rebuilds x/y from hsync/vsync/video_on and tracks lock to the mode.
// Optional `define TIMING_MEAS_EN exposes the last measured line/frame lengths.
module hdmi_sync_decoder
  import starsoc_video_pkg::*;
#(
  parameter int H_TOTAL  = VGA_H_TOTAL,
  parameter int V_TOTAL  = VGA_V_TOTAL,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1
) (
  input logic               clk,
  input logic               reset,
  hdmi_sync_decoder_if.slave vid
);

  localparam logic [11:0] HT    = 12'(H_TOTAL);
  localparam logic [10:0] VT    = 11'(V_TOTAL);
  localparam logic [9:0]  X_MAX = 10'(H_ACTIVE - 1);
  localparam logic [9:0]  Y_MAX = 10'(V_ACTIVE - 1);
  localparam logic [2:0]  SYNC_POL = {1'b1, VS_POL, HS_POL};

  // [0]=hsync [1]=vsync [2]=video_on
  logic [2:0] sync_in, sync_lvl, sync_rise, sync_fall;
  assign sync_in = {vid.video_on, vid.vsync, vid.hsync};

  for (genvar i = 0; i < 3; i++) begin : g_edge
    sync_edge_detect #(.POL(SYNC_POL[i])) u_edge (
      .clk    (clk),
      .reset  (reset),
      .p_tick (vid.p_tick),
      .sig_in (sync_in[i]),
      .lvl    (sync_lvl[i]),
      .rise   (sync_rise[i]),
      .fall   (sync_fall[i])
    );
  end

  logic tick, hs_edge, vs_edge, vo, vo_rise, vo_fall;
  assign tick    = vid.p_tick;
  assign hs_edge = sync_rise[0];
  assign vs_edge = sync_rise[1];
  assign vo      = sync_lvl[2];
  assign vo_rise = sync_rise[2];
  assign vo_fall = sync_fall[2];

  logic unused_sync;
  assign unused_sync = ^{sync_lvl[1:0], sync_fall[1:0]};

  logic [10:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d, vcnt_inc;
  logic [9:0]  xcnt_q, xcnt_d, ycnt_q, ycnt_d, x_cur;
  logic [9:0]  x_q, x_d, y_q, y_d;
  logic        pix_valid_q, pix_valid_d, frame_start_q, frame_start_d;
  logic        sync_err_q, sync_err_d, locked_q, locked_d;
  logic        skip_q, skip_d;
  sync_state_t state_q, state_d;
  logic [11:0] line_len;
  logic [10:0] frame_len;
  logic        h_bad, v_bad, h_lost;

  always_comb begin
    hcnt_d        = hcnt_q;
    vcnt_d        = vcnt_q;
    xcnt_d        = xcnt_q;
    ycnt_d        = ycnt_q;
    x_d           = x_q;
    y_d           = y_q;
    skip_d        = skip_q;
    state_d       = state_q;
    sync_err_d    = 1'b0;
    locked_d      = (state_q == LOCKED);

    // hsync is applied before vsync, so a coincident edge pair counts the line into F
    line_len  = {1'b0, hcnt_q} + 12'd1;
    vcnt_inc  = sat_inc11(vcnt_q);
    frame_len = hs_edge ? vcnt_inc : vcnt_q;
    x_cur     = vo_rise ? 10'd0 : ((xcnt_q >= X_MAX) ? X_MAX : xcnt_q + 10'd1);

    h_bad  = hs_edge & (line_len != HT);
    v_bad  = vs_edge & (frame_len != VT);
    // next tick would pin hcnt at 2047: hsync has gone missing
    h_lost = tick & ~hs_edge & (hcnt_q == 11'd2046);

    if (tick) begin
      hcnt_d = hs_edge ? 11'd0 : sat_inc11(hcnt_q);
      if (vs_edge)      vcnt_d = 11'd0;
      else if (hs_edge) vcnt_d = vcnt_inc;
      if (vo) begin
        xcnt_d = x_cur;
        x_d    = x_cur;
        y_d    = ycnt_q;
      end
      if (vs_edge)                        ycnt_d = 10'd0;
      else if (vo_fall && ycnt_q < Y_MAX) ycnt_d = ycnt_q + 10'd1;

      unique case (state_q)
        SEARCH: begin
          if (vs_edge) begin
            state_d = ACQUIRE;
            skip_d  = 1'b1;
          end
        end
        ACQUIRE: begin
          // line in flight at entry began before the reference vsync; ignore it
          if (hs_edge) skip_d = 1'b0;
          if ((h_bad && !skip_q) || v_bad) state_d = SEARCH;
          else if (vs_edge)                state_d = LOCKED;
        end
        LOCKED: begin
          if (h_bad || v_bad || h_lost) begin
            state_d    = SEARCH;
            sync_err_d = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    pix_valid_d   = tick & vo & locked_q;
    frame_start_d = pix_valid_d & (x_cur == 10'd0) & (ycnt_q == 10'd0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcnt_q        <= '0;
      vcnt_q        <= '0;
      xcnt_q        <= '0;
      ycnt_q        <= '0;
      x_q           <= '0;
      y_q           <= '0;
      pix_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
      skip_q        <= 1'b0;
      state_q       <= SEARCH;
    end else begin
      hcnt_q        <= hcnt_d;
      vcnt_q        <= vcnt_d;
      xcnt_q        <= xcnt_d;
      ycnt_q        <= ycnt_d;
      x_q           <= x_d;
      y_q           <= y_d;
      pix_valid_q   <= pix_valid_d;
      frame_start_q <= frame_start_d;
      sync_err_q    <= sync_err_d;
      locked_q      <= locked_d;
      skip_q        <= skip_d;
      state_q       <= state_d;
    end
  end

  assign vid.x           = x_q;
  assign vid.y           = y_q;
  assign vid.pix_valid   = pix_valid_q;
  assign vid.frame_start = frame_start_q;
  assign vid.sync_err    = sync_err_q;
  assign vid.locked      = locked_q;

`ifdef TIMING_MEAS_EN
  logic [10:0] h_meas_q, h_meas_d, v_meas_q, v_meas_d;

  always_comb begin
    h_meas_d = h_meas_q;
    v_meas_d = v_meas_q;
    if (hs_edge) h_meas_d = line_len[11] ? 11'h7FF : line_len[10:0];
    if (vs_edge) v_meas_d = frame_len;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_meas_q <= '0;
      v_meas_q <= '0;
    end else begin
      h_meas_q <= h_meas_d;
      v_meas_q <= v_meas_d;
    end
  end

  assign vid.h_total_meas = h_meas_q;
  assign vid.v_total_meas = v_meas_q;
`else
  assign vid.h_total_meas = '0;
  assign vid.v_total_meas = '0;
`endif

endmodule

// File: tb/tb_hdmi_sync_decoder.sv
// Directed bench for hdmi_sync_decoder on a reduced 16x11 mode, p_tick 1-in-4, with a
// second instance fed inverted syncs and configured for active-low polarity.
module tb_hdmi_sync_decoder;

  localparam int HA = 8, HFP = 2, HSW = 3, HBP = 3, HT = HA + HFP + HSW + HBP;
  localparam int VA = 6, VFP = 1, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
`ifdef TIMING_MEAS_EN
  localparam logic [10:0] EXP_HM = 11'd16, EXP_VM = 11'd11;
`else
  localparam logic [10:0] EXP_HM = 11'd0, EXP_VM = 11'd0;
`endif

  logic clk, reset;
  hdmi_sync_decoder_if bus ();
  hdmi_sync_decoder_if busn ();

  hdmi_sync_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
                      .HS_POL(1'b1), .VS_POL(1'b1)) u_dut (
    .clk(clk), .reset(reset), .vid(bus.slave));

  hdmi_sync_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .H_ACTIVE(HA), .V_ACTIVE(VA),
                      .HS_POL(1'b0), .VS_POL(1'b0)) u_dut_n (
    .clk(clk), .reset(reset), .vid(busn.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cur_h = 0, cur_v = 0;
  int pv = 0, fs = 0, se = 0, xe = 0, pvn = 0, fsn = 0, sen = 0, lkd = 0;

  // Observation counters; expected x/y come from the generator position of the sampled tick
  always @(negedge clk) begin
    if (bus.pix_valid) begin
      pv++;
      if (bus.x !== 10'(cur_h) || bus.y !== 10'(cur_v)) xe++;
    end
    if (bus.frame_start) begin
      fs++;
      if (!bus.pix_valid || bus.x !== 10'd0 || bus.y !== 10'd0) xe++;
    end
    if (bus.sync_err)   se++;
    if (busn.pix_valid) pvn++;
    if (busn.frame_start) fsn++;
    if (busn.sync_err)  sen++;
    if (bus.locked !== busn.locked) lkd++;
  end

  task automatic tick(input int v, input int h);
    bit hs, vs, vo;
    hs = (h >= HA + HFP) && (h < HA + HFP + HSW);
    vs = (v >= VA + VFP) && (v < VA + VFP + VSW);
    vo = (h < HA) && (v < VA);
    repeat (3) @(negedge clk);
    cur_h = h; cur_v = v;
    bus.p_tick = 1'b1;  bus.hsync = hs;   bus.vsync = vs;   bus.video_on = vo;
    busn.p_tick = 1'b1; busn.hsync = ~hs; busn.vsync = ~vs; busn.video_on = vo;
    @(negedge clk);
    bus.p_tick = 1'b0; busn.p_tick = 1'b0;
  endtask

  task automatic send_line(input int v, input int h0, input int len);
    for (int h = h0; h < len; h++) tick(v, h);
  endtask

  task automatic send_lines(input int v0, input int v1);
    for (int v = v0; v < v1; v++) send_line(v, 0, HT);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.p_tick = 0;  bus.hsync = 0;  bus.vsync = 0;  bus.video_on = 0;
    busn.p_tick = 0; busn.hsync = 1; busn.vsync = 1; busn.video_on = 0;
    repeat (3) @(negedge clk);
    total++; if (bus.x !== 10'd0 || bus.y !== 10'd0) begin bad++;
      $display("FAIL reset_xy: got x=%0d y=%0d want 0 0", bus.x, bus.y); end
    total++; if (bus.pix_valid !== 1'b0 || bus.frame_start !== 1'b0) begin bad++;
      $display("FAIL reset_pv_fs: got %b%b want 00", bus.pix_valid, bus.frame_start); end
    total++; if (bus.locked !== 1'b0 || bus.sync_err !== 1'b0) begin bad++;
      $display("FAIL reset_lock_err: got %b%b want 00", bus.locked, bus.sync_err); end
    total++; if (bus.h_total_meas !== 11'd0 || bus.v_total_meas !== 11'd0) begin bad++;
      $display("FAIL reset_meas: got %0d %0d want 0 0", bus.h_total_meas, bus.v_total_meas); end
    total++; if (busn.locked !== 1'b0 || busn.pix_valid !== 1'b0) begin bad++;
      $display("FAIL reset_inv: got %b%b want 00", busn.locked, busn.pix_valid); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_lock;
    int p0, f0, x0, s0, n0, g0, e0;
    send_lines(0, VT);
    total++; if (bus.locked !== 1'b0) begin bad++;
      $display("FAIL lock_frame1: got %b want 0", bus.locked); end
    send_lines(0, 7);
    tick(7, 0);
    total++; if (bus.locked !== 1'b0) begin bad++;
      $display("FAIL lock_at_edge: got %b want 0", bus.locked); end
    @(negedge clk);
    total++; if (bus.locked !== 1'b1) begin bad++;
      $display("FAIL lock_next_clk: got %b want 1", bus.locked); end
    send_line(7, 1, HT);
    send_lines(8, VT);
    p0 = pv; f0 = fs; x0 = xe; s0 = se; n0 = pvn; g0 = fsn; e0 = sen;
    send_lines(0, VT);
    total++; if (pv - p0 != HA * VA) begin bad++;
      $display("FAIL frame_pix: got %0d want %0d", pv - p0, HA * VA); end
    total++; if (fs - f0 != 1) begin bad++;
      $display("FAIL frame_start_cnt: got %0d want 1", fs - f0); end
    total++; if (xe != x0) begin bad++;
      $display("FAIL frame_xy: got %0d bad pixels want 0", xe - x0); end
    total++; if (se != s0 || sen != e0) begin bad++;
      $display("FAIL frame_no_err: got %0d/%0d want 0/0", se - s0, sen - e0); end
    total++; if (pvn - n0 != HA * VA || fsn - g0 != 1) begin bad++;
      $display("FAIL inv_frame: got pix=%0d fs=%0d want %0d 1", pvn - n0, fsn - g0, HA * VA); end
    total++; if (bus.locked !== 1'b1) begin bad++;
      $display("FAIL lock_hold: got %b want 1", bus.locked); end
  endtask

  task automatic test_meas;
    total++; if (bus.h_total_meas !== EXP_HM) begin bad++;
      $display("FAIL h_meas: got %0d want %0d", bus.h_total_meas, EXP_HM); end
    total++; if (bus.v_total_meas !== EXP_VM) begin bad++;
      $display("FAIL v_meas: got %0d want %0d", bus.v_total_meas, EXP_VM); end
    total++; if (busn.h_total_meas !== EXP_HM || busn.v_total_meas !== EXP_VM) begin bad++;
      $display("FAIL inv_meas: got %0d %0d want %0d %0d", busn.h_total_meas,
               busn.v_total_meas, EXP_HM, EXP_VM); end
  endtask

  task automatic test_short_line;
    int s0, e0;
    s0 = se; e0 = sen;
    send_lines(0, 3);
    send_line(3, 0, HT - 1);
    send_line(4, 0, 10);
    total++; if (se != s0) begin bad++;
      $display("FAIL short_early_err: got %0d want 0", se - s0); end
    tick(4, 10);
    total++; if (bus.sync_err !== 1'b1 || bus.locked !== 1'b1) begin bad++;
      $display("FAIL short_err_pulse: got err=%b lock=%b want 1 1", bus.sync_err, bus.locked); end
    @(negedge clk);
    total++; if (bus.sync_err !== 1'b0 || bus.locked !== 1'b0) begin bad++;
      $display("FAIL short_drop: got err=%b lock=%b want 0 0", bus.sync_err, bus.locked); end
    send_line(4, 11, HT);
    send_lines(5, VT);
    send_lines(0, 7);
    total++; if (bus.locked !== 1'b0) begin bad++;
      $display("FAIL short_acquire: got %b want 0", bus.locked); end
    tick(7, 0);
    @(negedge clk);
    total++; if (bus.locked !== 1'b1) begin bad++;
      $display("FAIL short_relock: got %b want 1", bus.locked); end
    send_line(7, 1, HT);
    send_lines(8, VT);
    total++; if (se - s0 != 1 || sen - e0 != 1) begin bad++;
      $display("FAIL short_err_cnt: got %0d/%0d want 1/1", se - s0, sen - e0); end
  endtask

  task automatic test_reset_midline;
    send_lines(0, 2);
    send_line(2, 0, 3);
    tick(2, 3);
    total++; if (bus.pix_valid !== 1'b1 || bus.x !== 10'd3 || bus.y !== 10'd2) begin bad++;
      $display("FAIL pre_reset_pix: got pv=%b x=%0d y=%0d want 1 3 2", bus.pix_valid, bus.x, bus.y); end
    #2 reset = 1'b1;
    #1;
    total++; if ({bus.x, bus.y, bus.pix_valid, bus.frame_start, bus.locked, bus.sync_err} !== '0)
      begin bad++;
      $display("FAIL async_reset: got x=%0d y=%0d pv=%b fs=%b lk=%b err=%b want all 0",
               bus.x, bus.y, bus.pix_valid, bus.frame_start, bus.locked, bus.sync_err); end
    total++; if (bus.h_total_meas !== 11'd0 || busn.locked !== 1'b0 || busn.x !== 10'd0) begin bad++;
      $display("FAIL async_reset_misc: got hm=%0d lkn=%b xn=%0d want 0 0 0",
               bus.h_total_meas, busn.locked, busn.x); end
    @(negedge clk);
    reset = 1'b0;
    send_line(2, 4, HT);
    send_lines(3, VT);
    total++; if (bus.locked !== 1'b0) begin bad++;
      $display("FAIL post_reset_search: got %b want 0", bus.locked); end
    send_lines(0, 7);
    total++; if (bus.locked !== 1'b0) begin bad++;
      $display("FAIL post_reset_acquire: got %b want 0", bus.locked); end
    tick(7, 0);
    @(negedge clk);
    total++; if (bus.locked !== 1'b1) begin bad++;
      $display("FAIL post_reset_relock: got %b want 1", bus.locked); end
    send_line(7, 1, HT);
    send_lines(8, VT);
  endtask

  task automatic test_drop_line;
    int s0, e0;
    s0 = se; e0 = sen;
    send_lines(0, VT - 1);
    send_lines(0, 7);
    total++; if (se != s0 || bus.locked !== 1'b1) begin bad++;
      $display("FAIL drop_early: got err=%0d lock=%b want 0 1", se - s0, bus.locked); end
    tick(7, 0);
    total++; if (bus.sync_err !== 1'b1) begin bad++;
      $display("FAIL drop_err_pulse: got %b want 1", bus.sync_err); end
    @(negedge clk);
    total++; if (bus.locked !== 1'b0) begin bad++;
      $display("FAIL drop_unlock: got %b want 0", bus.locked); end
    send_line(7, 1, HT);
    send_lines(8, VT);
    total++; if (se - s0 != 1 || sen - e0 != 1) begin bad++;
      $display("FAIL drop_err_cnt: got %0d/%0d want 1/1", se - s0, sen - e0); end
    total++; if (lkd != 0) begin bad++;
      $display("FAIL inv_lock_track: got %0d differing clks want 0", lkd); end
  endtask

  initial begin
    test_reset;
    test_lock;
    test_meas;
    test_short_line;
    test_reset_midline;
    test_drop_line;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
